// File: rtl/cofactor_pkg.sv
// ============================================================================
// Module  : cofactor_pkg
// Purpose : Shared types for the cofactor amplitude-RAM arbiter: the arbiter
//           FSM state encoding, the read-return tag and width helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cofactor_pkg;

    // Default geometry of the amplitude RAM
    localparam int c_DEF_NUM_QUBIT = 3;
    localparam int c_DEF_DATA_W    = 32;

    // Arbiter FSM; encoding is visible on the arb_state debug port.
    // The fourth code is unused and recovers to ST_OPEN.
    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

    // Owner of a read travelling through the RAM pipeline
    typedef struct packed {
        logic a;
        logic b;
    } rd_tag_t;

    // Width of a counter that must be able to hold the value 'limit'
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage : cofactor_pkg

`default_nettype wire

// File: rtl/rd_tag_pipe.sv
// ============================================================================
// Module  : rd_tag_pipe
// Purpose : Shift register that carries the owner tag of each RAM read so the
//           returning data can be routed to the requester that issued it.
// Ports   : clk     - clock
//           rst     - asynchronous active-low reset, clears all stages
//           tag_in  - owner of the read granted this cycle
//           tag_out - owner of the read whose data is on ram_rdata now
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rd_tag_pipe
    import cofactor_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign tag_out = r_pipe[DEPTH-1];

endmodule : rd_tag_pipe

`default_nettype wire

// File: rtl/cofactor_ram_arbiter.sv
// ============================================================================
// Module  : cofactor_ram_arbiter
// Purpose : Shares the amplitude RAM read port between the free-running
//           cofactor address generator (A, absolute priority) and the host
//           readout path (B, request/grant). B is protected from starvation
//           by forcing the generator's index-FIFO-empty view high so that no
//           new cofactor pass can start; a pass in progress always completes.
// Ports   : clk, rst (async active-low)
//           a_address_valid/a_read_address/a_idle  - generator side
//           index_fifo_empty_in/_out               - FIFO empty gating
//           b_req/b_addr/b_gnt                     - host request/grant
//           ram_re/ram_addr/ram_rdata              - RAM read port
//           rdata/a_rvalid/b_rvalid                - tagged read return
//           arb_state                              - FSM state for debug
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cofactor_ram_arbiter
    import cofactor_pkg::*;
#(
    parameter int num_qubit    = c_DEF_NUM_QUBIT,
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_address_valid,
    input  logic [num_qubit-1:0] a_read_address,
    input  logic                 a_idle,
    input  logic                 index_fifo_empty_in,
    output logic                 index_fifo_empty_out,
    input  logic                 b_req,
    input  logic [num_qubit-1:0] b_addr,
    output logic                 b_gnt,
    output logic                 ram_re,
    output logic [num_qubit-1:0] ram_addr,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 a_rvalid,
    output logic                 b_rvalid,
    output logic [1:0]           arb_state
);

    localparam int                c_CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic                 w_b_gnt;
    logic                 w_b_done;
    logic                 r_ram_re;
    logic [num_qubit-1:0] r_ram_addr;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    arb_state_t           r_state;
    arb_state_t           w_state_next;
    rd_tag_t              w_tag_in;
    rd_tag_t              w_tag_out;

    // A owns any cycle it strobes; B is granted independently of FSM state
    assign w_b_gnt  = b_req & ~a_address_valid;
    // The current B request is over: either served or withdrawn
    assign w_b_done = w_b_gnt | ~b_req;
    assign b_gnt    = w_b_gnt;

    // ------------------------------------------------------------------
    // Read issue: one registered slot per cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_re   <= 1'b0;
            r_ram_addr <= '0;
        end else begin
            r_ram_re <= a_address_valid | w_b_gnt;
            if (a_address_valid) begin
                r_ram_addr <= a_read_address;
            end else if (w_b_gnt) begin
                r_ram_addr <= b_addr;
            end
        end
    end

    assign ram_re   = r_ram_re;
    assign ram_addr = r_ram_addr;

    // ------------------------------------------------------------------
    // Return routing: tag enters at grant, exits with the RAM data
    // ------------------------------------------------------------------
    assign w_tag_in = '{a: a_address_valid, b: w_b_gnt};

    rd_tag_pipe #(
        .DEPTH (1 + READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    assign a_rvalid = w_tag_out.a;
    assign b_rvalid = w_tag_out.b;
    assign rdata    = ram_rdata;

    // ------------------------------------------------------------------
    // Starvation counter: consecutive blocked B cycles, saturating
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (w_b_done) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_LIMIT) begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Gating FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OPEN: begin
                // An idle generator has no pass to finish, so block at once
                if (r_wait_cnt == c_LIMIT) begin
                    w_state_next = a_idle ? ST_HOLD : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_b_done) begin
                    w_state_next = ST_OPEN;
                end else if (a_idle) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_b_done) begin
                    w_state_next = ST_OPEN;
                end
            end
            default: begin
                w_state_next = ST_OPEN;
            end
        endcase
    end

    // Decoded from the registered state only, so it cannot glitch mid-cycle
    assign index_fifo_empty_out = (r_state == ST_OPEN) ? index_fifo_empty_in : 1'b1;
    assign arb_state            = r_state;

endmodule : cofactor_ram_arbiter

`default_nettype wire
